// File: rtl/nios_system_scanner_clk_seq.sv
// rtl/nios_system_scanner_clk_seq.sv - Avalon-MM scanner clock pulse-train generator; optional irq via SCANNER_CLK_IRQ_EN
module nios_system_scanner_clk_seq #(
  parameter int DIV_W = 16,
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        out_port
`ifdef SCANNER_CLK_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HIGH = 2'd1;
  localparam logic [1:0] S_LOW  = 2'd2;

  logic [1:0]       r_state;
  logic             r_out;
  logic [DIV_W-1:0] r_div;
  logic [CNT_W-1:0] r_count;
  logic             r_cont;
  logic             r_done;
  logic [DIV_W-1:0] r_per;
  logic [DIV_W-1:0] r_phase;
  logic [CNT_W-1:0] r_rem;

  logic             w_wr;
  logic             w_wr_ctrl;
  logic             w_start;
  logic             w_stop;
  logic             w_clr;
  logic             w_busy;
  logic             w_go;
  logic             w_phase_end;
  logic             w_last;
  logic             w_done_set;
  logic             w_irq_en;
  logic [DIV_W-1:0] w_div_eff;
  logic             w_unused;

  assign w_wr        = chipselect & ~write_n;
  assign w_wr_ctrl   = w_wr & (address == 2'd0);
  assign w_start     = w_wr_ctrl & writedata[0];
  assign w_stop      = w_wr_ctrl & writedata[1];
  assign w_clr       = w_wr & (address == 2'd3) & writedata[1];
  assign w_busy      = (r_state != S_IDLE);
  assign w_div_eff   = (r_div == '0) ? DIV_W'(1) : r_div;
  // Continuous mode may be requested in the very write that carries start.
  assign w_go        = w_start & ~w_stop & ~w_busy & ((r_count != '0) | writedata[2]);
  assign w_phase_end = (r_phase == '0);
  // rem<=1 also ends a train whose cont bit was dropped after starting with COUNT=0.
  assign w_last      = ~r_cont & (r_rem <= CNT_W'(1));
  assign w_done_set  = (r_state == S_LOW) & w_phase_end & ~w_stop & w_last;
  assign w_unused    = &{1'b0, writedata};
  assign out_port    = r_out;

  // Software-visible configuration registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div   <= DIV_W'(1);
      r_count <= '0;
      r_cont  <= 1'b0;
    end else if (w_wr) begin
      if (address == 2'd0) r_cont  <= writedata[2];
      if (address == 2'd1) r_div   <= writedata[DIV_W-1:0];
      if (address == 2'd2) r_count <= writedata[CNT_W-1:0];
    end
  end

  // Pulse-train sequencer; the period is latched at start so DIV writes wait for the next run.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_out   <= 1'b0;
      r_per   <= DIV_W'(1);
      r_phase <= '0;
      r_rem   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_go) begin
            r_state <= S_HIGH;
            r_out   <= 1'b1;
            r_per   <= w_div_eff;
            r_phase <= w_div_eff - DIV_W'(1);
            r_rem   <= r_count;
          end
        end
        S_HIGH: begin
          if (w_stop) begin
            r_state <= S_IDLE;
            r_out   <= 1'b0;
          end else if (w_phase_end) begin
            r_state <= S_LOW;
            r_out   <= 1'b0;
            r_phase <= r_per - DIV_W'(1);
          end else begin
            r_phase <= r_phase - DIV_W'(1);
          end
        end
        S_LOW: begin
          if (w_stop) begin
            r_state <= S_IDLE;
            r_out   <= 1'b0;
          end else if (w_phase_end) begin
            if (!r_cont && r_rem != '0) r_rem <= r_rem - CNT_W'(1);
            if (w_last) begin
              r_state <= S_IDLE;
            end else begin
              r_state <= S_HIGH;
              r_out   <= 1'b1;
              r_phase <= r_per - DIV_W'(1);
            end
          end else begin
            r_phase <= r_phase - DIV_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_out   <= 1'b0;
        end
      endcase
    end
  end

  // Sticky done flag: completion beats a same-cycle clear, start clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_done <= 1'b0;
    end else if (w_done_set) begin
      r_done <= 1'b1;
    end else if (w_go || w_clr) begin
      r_done <= 1'b0;
    end
  end

`ifdef SCANNER_CLK_IRQ_EN
  logic r_irq_en;
  logic r_irq;

  // Interrupt enable bit and registered done interrupt.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr_ctrl) r_irq_en <= writedata[3];
      r_irq <= r_done & r_irq_en;
    end
  end

  assign w_irq_en = r_irq_en;
  assign irq      = r_irq;
`else
  assign w_irq_en = 1'b0;
`endif

  // Zero-wait-state read mux.
  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata = {28'd0, w_irq_en, r_cont, 1'b0, w_busy};
      2'd1:    readdata = 32'(r_div);
      2'd2:    readdata = 32'(r_count);
      default: readdata = {16'(r_rem), 14'd0, r_done, w_busy};
    endcase
  end

endmodule

// File: tb/tb_nios_system_scanner_clk_seq.sv
// tb/tb_nios_system_scanner_clk_seq.sv - self-checking bench for nios_system_scanner_clk_seq
module tb_nios_system_scanner_clk_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        out_port;
`ifdef SCANNER_CLK_IRQ_EN
  logic        irq;
`endif

  nios_system_scanner_clk_seq dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
`ifdef SCANNER_CLK_IRQ_EN
    .irq        (irq),
`endif
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit exp_q[$];

  typedef struct {
    logic [15:0] div;
    logic [15:0] cnt;
    logic [31:0] stat;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard consumer: one expected out_port value per clock, sampled after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        bit e;
        e = exp_q.pop_front();
        check("out_port", {31'd0, out_port}, {31'd0, e});
      end
    end
  end

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  task automatic read_check(input string name, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check(name, d, exp);
  endtask

  // Ideal 50% duty waveform: high for d cycles, low for d cycles, from the start edge.
  task automatic push_pattern(input int div, input int len);
    int de;
    de = (div == 0) ? 1 : div;
    for (int i = 0; i < len; i++) exp_q.push_back(((i / de) % 2) == 0);
  endtask

  task automatic push_train(input int div, input int cnt);
    int de;
    de = (div == 0) ? 1 : div;
    push_pattern(div, 2 * de * cnt);
    exp_q.push_back(1'b0);
  endtask

  task automatic wait_drain(input string name, input int maxc);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < maxc) begin
      @(negedge clk);
      k++;
    end
    check({"drain_", name}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    logic [31:0] d;
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;

    tbl[0] = '{div: 16'd2, cnt: 16'd3, stat: 32'h2};
    tbl[1] = '{div: 16'd0, cnt: 16'd2, stat: 32'h2};
    tbl[2] = '{div: 16'd1, cnt: 16'd1, stat: 32'h2};
    tbl[3] = '{div: 16'd3, cnt: 16'd2, stat: 32'h2};
    tbl[4] = '{div: 16'd5, cnt: 16'd1, stat: 32'h2};
    tbl[5] = '{div: 16'd4, cnt: 16'd0, stat: 32'h0};

    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    read_check("rst_ctrl", 2'd0, 32'h0);
    read_check("rst_div", 2'd1, 32'h1);
    read_check("rst_count", 2'd2, 32'h0);
    read_check("rst_stat", 2'd3, 32'h0);
    check("rst_out", {31'd0, out_port}, 32'h0);

    for (int i = 0; i < 6; i++) begin
      bus_write(2'd3, 32'h2);
      bus_write(2'd1, 32'(tbl[i].div));
      bus_write(2'd2, 32'(tbl[i].cnt));
      push_train(tbl[i].div, tbl[i].cnt);
      bus_write(2'd0, 32'h1);
      wait_drain($sformatf("vec%0d", i), 400);
      read_check($sformatf("vec%0d_stat", i), 2'd3, tbl[i].stat);
      read_check($sformatf("vec%0d_div", i), 2'd1, 32'(tbl[i].div));
      check($sformatf("vec%0d_out_idle", i), {31'd0, out_port}, 32'h0);
    end

    // Stop mid-train: done stays clear, remaining count frozen at 9.
    bus_write(2'd1, 32'd4);
    bus_write(2'd2, 32'd10);
    push_pattern(4, 14);
    exp_q.push_back(1'b0);
    bus_write(2'd0, 32'h1);
    repeat (13) @(negedge clk);
    bus_write(2'd0, 32'h2);
    wait_drain("stop", 40);
    read_check("stop_stat", 2'd3, 32'h0009_0000);
    read_check("stop_ctrl", 2'd0, 32'h0);

    // start and stop together from idle: stop wins.
    bus_write(2'd0, 32'h3);
    read_check("startstop_ctrl", 2'd0, 32'h0);
    check("startstop_out", {31'd0, out_port}, 32'h0);

    // Continuous mode with COUNT=0; restart and DIV write mid-run must not disturb timing.
    bus_write(2'd1, 32'd1);
    bus_write(2'd2, 32'd0);
    push_pattern(1, 20);
    bus_write(2'd0, 32'h5);
    repeat (4) @(negedge clk);
    read_check("cont_ctrl", 2'd0, 32'h5);
    bus_write(2'd0, 32'h5);
    bus_write(2'd1, 32'd3);
    wait_drain("cont", 60);
    bus_write(2'd0, 32'h2);
    read_check("cont_stop_ctrl", 2'd0, 32'h0);
    check("cont_stop_out", {31'd0, out_port}, 32'h0);
    read_check("cont_div", 2'd1, 32'h3);

`ifdef SCANNER_CLK_IRQ_EN
    bus_write(2'd1, 32'd1);
    bus_write(2'd2, 32'd1);
    bus_write(2'd0, 32'h9);
    repeat (3) @(negedge clk);
    check("irq_set", {31'd0, irq}, 32'h1);
    read_check("irq_ctrl", 2'd0, 32'h8);
    bus_write(2'd3, 32'h2);
    @(negedge clk);
    check("irq_clr", {31'd0, irq}, 32'h0);
`else
    bus_write(2'd0, 32'h8);
    read_check("irq_en_absent", 2'd0, 32'h0);
`endif

    // Asynchronous reset in the middle of a train.
    bus_write(2'd1, 32'd2);
    bus_write(2'd2, 32'd5);
    bus_write(2'd0, 32'h1);
    repeat (3) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_out", {31'd0, out_port}, 32'h0);
    read_check("arst_ctrl", 2'd0, 32'h0);
    read_check("arst_div", 2'd1, 32'h1);
    read_check("arst_count", 2'd2, 32'h0);
    read_check("arst_stat", 2'd3, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
